// File: rtl/iq_fetch_sequencer_pkg.sv
// Shared types and constants for the fetch/align/instruction-queue sequencer.
package iq_ctrl_pkg;
   localparam int ISSUE_WIDTH_DEF = 4;
   localparam int BUFFER_SIZE_DEF = 10;
   localparam int FETCH_MAX_DEF   = 4;
   localparam int PC_W_DEF        = 32;
   localparam int INSN_BYTES      = 4;
   localparam logic [31:0] NOP_INSN = 32'h0000_0013;
   localparam logic [7:0]  CUT_NONE = 8'hFF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DRAIN,
      S_FLUSH
   } iq_state_e;
endpackage

// File: rtl/iq_fetch_sequencer_if.sv
// Fetch, queue and issue handshake bundle for iq_fetch_sequencer.
interface iq_fetch_sequencer_if #(parameter int PC_W = 32);
   logic            i_redirect_valid;
   logic [PC_W-1:0] i_redirect_pc;
   logic            o_fetch_req;
   logic [PC_W-1:0] o_fetch_pc;
   logic            i_fetch_ack;
   logic            i_fetch_valid;
   logic [7:0]      i_cut_pos;
   logic            o_queue_push;
   logic [7:0]      o_queue_cut;
   logic            o_queue_flush;
   logic            i_issue_ready;
   logic            o_issue_valid;
   logic [7:0]      o_count;
   logic            o_err;

   modport master (
      input  i_redirect_valid, i_redirect_pc, i_fetch_ack, i_fetch_valid, i_cut_pos, i_issue_ready,
      output o_fetch_req, o_fetch_pc, o_queue_push, o_queue_cut, o_queue_flush, o_issue_valid,
             o_count, o_err
   );

   modport slave (
      output i_redirect_valid, i_redirect_pc, i_fetch_ack, i_fetch_valid, i_cut_pos, i_issue_ready,
      input  o_fetch_req, o_fetch_pc, o_queue_push, o_queue_cut, o_queue_flush, o_issue_valid,
             o_count, o_err
   );
endinterface

// File: rtl/iq_fetch_sequencer_credit_counter.sv
// Queue occupancy tracker: push/pop/flush arithmetic and room checks.
module iq_credit_counter #(
   parameter int ISSUE_WIDTH = 4,
   parameter int BUFFER_SIZE = 10,
   parameter int FETCH_MAX   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       flush,
   input  logic       push,
   input  logic [7:0] push_amt,
   input  logic       pop_req,
   output logic       pop,
   output logic [7:0] count,
   output logic       room_now,
   output logic       room_next
);
   localparam logic [7:0] IW8   = 8'(ISSUE_WIDTH);
   localparam logic [7:0] LIMIT = 8'(BUFFER_SIZE - FETCH_MAX);

   logic [7:0] count_q, count_d, pop_amt;

   always_comb begin
      pop     = pop_req && (count_q != 8'd0);
      pop_amt = (count_q < IW8) ? count_q : IW8;
      count_d = count_q;
      if (flush) begin
         count_d = 8'd0;
      end else begin
         if (push) count_d = count_d + push_amt;
         if (pop)  count_d = count_d - pop_amt;
      end
      room_now  = count_q <= LIMIT;
      room_next = count_d <= LIMIT;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) count_q <= 8'd0;
      else     count_q <= count_d;
   end

   assign count = count_q;

   a_count_bound: assert property (@(posedge clk) disable iff (rst) count_q <= 8'(BUFFER_SIZE));
endmodule

// File: rtl/iq_fetch_sequencer.sv
// Fetch/align/instruction-queue sequencer. Optional perf counters: IQ_FETCH_PERF_EN.
module iq_fetch_sequencer
   import iq_ctrl_pkg::*;
#(
   parameter int              ISSUE_WIDTH = ISSUE_WIDTH_DEF,
   parameter int              BUFFER_SIZE = BUFFER_SIZE_DEF,
   parameter int              FETCH_MAX   = FETCH_MAX_DEF,
   parameter int              PC_W        = PC_W_DEF,
   parameter logic [PC_W-1:0] RESET_PC    = '0
) (
   input logic clk,
   input logic rst,
   iq_fetch_sequencer_if.master bus
`ifdef IQ_FETCH_PERF_EN
   ,
   output logic [31:0] o_perf_fetches,
   output logic [31:0] o_perf_room_stalls,
   output logic [31:0] o_perf_redirects
`endif
);
   localparam logic [7:0]      FMAX8     = 8'(FETCH_MAX);
   localparam logic [PC_W-1:0] FULL_STEP = PC_W'(FETCH_MAX * INSN_BYTES);

   iq_state_e       state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d, pc_step;
   logic            pend_q, pend_d, err_q, err_d;
   logic            redirect, cut_none, cut_oor, push, in_flight;
   logic [7:0]      cut_c, count;
   logic            room_now, room_next, pop;

   always_comb begin
      redirect = bus.i_redirect_valid;
      cut_none = bus.i_cut_pos == CUT_NONE;
      cut_oor  = !cut_none && (bus.i_cut_pos >= FMAX8);
      cut_c    = cut_oor ? FMAX8 - 8'd1 : bus.i_cut_pos;
      push     = (state_q == S_WAIT) && bus.i_fetch_valid && !redirect && !cut_none;
      pc_step  = cut_none ? FULL_STEP : PC_W'((32'(cut_c) + 32'd1) * 32'(INSN_BYTES));
   end

   iq_credit_counter #(
      .ISSUE_WIDTH(ISSUE_WIDTH), .BUFFER_SIZE(BUFFER_SIZE), .FETCH_MAX(FETCH_MAX)
   ) u_credit (
      .clk, .rst,
      .flush    (redirect),
      .push     (push),
      .push_amt (cut_c + 8'd1),
      .pop_req  (bus.i_issue_ready && !redirect),
      .pop      (pop),
      .count    (count),
      .room_now (room_now),
      .room_next(room_next)
   );

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      pend_d    = pend_q;
      err_d     = err_q | (push && cut_oor);
      // A response is still owed if this cycle's ack landed or an earlier one is unreturned.
      in_flight = ((state_q == S_REQ) && bus.i_fetch_ack) || (pend_q && !bus.i_fetch_valid);
      if (redirect) begin
         pc_d    = bus.i_redirect_pc;
         pend_d  = in_flight;
         state_d = (state_q == S_DRAIN) ? (in_flight ? S_DRAIN : S_IDLE) : S_FLUSH;
      end else begin
         unique case (state_q)
            S_IDLE: if (room_now) state_d = S_REQ;
            S_REQ: if (bus.i_fetch_ack) begin
               state_d = S_WAIT;
               pend_d  = 1'b1;
            end
            // Room is judged on the post-push count: the next group is not yet counted.
            S_WAIT: if (bus.i_fetch_valid) begin
               pend_d  = 1'b0;
               pc_d    = pc_q + pc_step;
               state_d = room_next ? S_REQ : S_IDLE;
            end
            S_FLUSH: begin
               state_d = (pend_q && !bus.i_fetch_valid) ? S_DRAIN : S_IDLE;
               if (bus.i_fetch_valid) pend_d = 1'b0;
            end
            S_DRAIN: if (bus.i_fetch_valid) begin
               pend_d  = 1'b0;
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         pend_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         pend_q  <= pend_d;
         err_q   <= err_d;
      end
   end

   assign bus.o_fetch_req   = state_q == S_REQ;
   assign bus.o_fetch_pc    = pc_q;
   assign bus.o_queue_flush = state_q == S_FLUSH;
   assign bus.o_queue_push  = push;
   assign bus.o_queue_cut   = push ? cut_c : 8'd0;
   assign bus.o_issue_valid = pop;
   assign bus.o_count       = count;
   assign bus.o_err         = err_q;

`ifdef IQ_FETCH_PERF_EN
   logic [31:0] pf_fetch_q, pf_fetch_d, pf_stall_q, pf_stall_d, pf_redir_q, pf_redir_d;

   always_comb begin
      pf_fetch_d = pf_fetch_q;
      pf_stall_d = pf_stall_q;
      pf_redir_d = pf_redir_q;
      if ((state_q == S_REQ) && bus.i_fetch_ack && (pf_fetch_q != '1)) pf_fetch_d = pf_fetch_q + 32'd1;
      if ((state_q == S_IDLE) && !room_now && (pf_stall_q != '1))       pf_stall_d = pf_stall_q + 32'd1;
      if (redirect && (pf_redir_q != '1))                                pf_redir_d = pf_redir_q + 32'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pf_fetch_q <= '0;
         pf_stall_q <= '0;
         pf_redir_q <= '0;
      end else begin
         pf_fetch_q <= pf_fetch_d;
         pf_stall_q <= pf_stall_d;
         pf_redir_q <= pf_redir_d;
      end
   end

   assign o_perf_fetches     = pf_fetch_q;
   assign o_perf_room_stalls = pf_stall_q;
   assign o_perf_redirects   = pf_redir_q;
`endif
endmodule
